// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types and opcode classification helpers
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE,
        IND,
        ACCESS,
        DONE
    } mem_state_t;

    function automatic logic is_mem_op(input lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_ldi) ||
               (op == op_str) || (op == op_stb) || (op == op_sti);
    endfunction

    function automatic logic is_indirect_op(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_load_op(input lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
    endfunction

    function automatic logic is_byte_op(input lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// rtl/mem_byte_align.sv - byte-lane steering for stores and zero-extending byte loads
module mem_byte_align
    import lc3b_types::*;
(
    input  lc3b_opcode  opcode_i,
    input  logic        addr_lsb_i,
    input  lc3b_word    store_data_i,
    input  lc3b_word    rdata_i,
    output lc3b_word    wdata_o,
    output logic [1:0]  byte_enable_o,
    output lc3b_word    load_data_o
);

    always_comb begin
        wdata_o       = store_data_i;
        byte_enable_o = 2'b11;
        load_data_o   = rdata_i;
        if (opcode_i == op_stb) begin
            // Replicate the byte so either lane carries it; the enable picks the lane.
            wdata_o       = {store_data_i[7:0], store_data_i[7:0]};
            byte_enable_o = addr_lsb_i ? 2'b10 : 2'b01;
        end
        if (opcode_i == op_ldb) begin
            load_data_o = {8'h00, (addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0])};
        end
    end

endmodule

// File: rtl/register.sv
// rtl/register.sv - width-parameterised load-enable register with async active-low clear
module register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-cache sequencer for LC-3b loads/stores incl. indirect
module mem_access_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  lc3b_opcode  mem_opcode,
    input  lc3b_word    mem_address,
    input  lc3b_word    mem_store_data,
    input  logic        dmem_resp,
    input  lc3b_word    dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output lc3b_word    dmem_address,
    output lc3b_word    dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output lc3b_word    mem_rdata,
    output logic        mem_stall
);

    mem_state_t  state_q;
    logic        read_q;
    logic        write_q;
    lc3b_word    addr_q;
    lc3b_word    wdata_q;
    logic [1:0]  be_q;

    lc3b_word    ptr_q;
    lc3b_word    ptr_d;
    logic        ptr_load;
    logic        rdata_load;

    lc3b_word    align_wdata;
    lc3b_word    align_load;
    logic [1:0]  align_be;

    logic        op_is_mem;
    logic        op_is_ind;
    logic        op_is_load;
    logic        op_is_byte;
    lc3b_word    word_addr;

    assign op_is_mem  = is_mem_op(mem_opcode);
    assign op_is_ind  = is_indirect_op(mem_opcode);
    assign op_is_load = is_load_op(mem_opcode);
    assign op_is_byte = is_byte_op(mem_opcode);
    assign word_addr  = {mem_address[15:1], 1'b0};

    mem_byte_align u_align (
        .opcode_i      (mem_opcode),
        .addr_lsb_i    (mem_address[0]),
        .store_data_i  (mem_store_data),
        .rdata_i       (dmem_rdata),
        .wdata_o       (align_wdata),
        .byte_enable_o (align_be),
        .load_data_o   (align_load)
    );

    // Pointer is only ever used as a word address, so bit 0 is dropped on capture.
    assign ptr_load = (state_q == IND) && dmem_resp;
    assign ptr_d    = {dmem_rdata[15:1], 1'b0};

    register #(.WIDTH(16)) u_ptr_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ptr_load),
        .din     (ptr_d),
        .dout    (ptr_q)
    );

    assign rdata_load = (state_q == ACCESS) && dmem_resp && op_is_load;

    register #(.WIDTH(16)) u_rdata_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rdata_load),
        .din     (align_load),
        .dout    (mem_rdata)
    );

    // Request fields are loaded on entry to IND/ACCESS and cleared on the final response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_valid && op_is_mem) begin
                        if (op_is_ind) begin
                            state_q <= IND;
                            read_q  <= 1'b1;
                            write_q <= 1'b0;
                            addr_q  <= word_addr;
                            wdata_q <= mem_store_data;
                            be_q    <= 2'b11;
                        end else begin
                            state_q <= ACCESS;
                            read_q  <= op_is_load;
                            write_q <= !op_is_load;
                            addr_q  <= op_is_byte ? mem_address : word_addr;
                            wdata_q <= align_wdata;
                            be_q    <= align_be;
                        end
                    end
                end
                IND: begin
                    if (dmem_resp) begin
                        state_q <= ACCESS;
                        read_q  <= op_is_load;
                        write_q <= !op_is_load;
                        wdata_q <= align_wdata;
                        be_q    <= align_be;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        state_q <= DONE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        be_q    <= 2'b00;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem_read        = read_q;
    assign dmem_write       = write_q;
    assign dmem_address     = ((state_q == ACCESS) && op_is_ind) ? ptr_q : addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;
    assign mem_stall        = mem_valid && op_is_mem && (state_q != DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench with a transaction-level cache model
module tb_mem_access_ctrl;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    lc3b_opcode  mem_opcode;
    lc3b_word    mem_address;
    lc3b_word    mem_store_data;
    logic        dmem_resp;
    lc3b_word    dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    lc3b_word    dmem_address;
    lc3b_word    dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    lc3b_word    mem_rdata;
    logic        mem_stall;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_valid        (mem_valid),
        .mem_opcode       (mem_opcode),
        .mem_address      (mem_address),
        .mem_store_data   (mem_store_data),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_rdata        (mem_rdata),
        .mem_stall        (mem_stall)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] mem_m [0:32767];
    lc3b_word    model_rdata;
    int          last_stalls;
    lc3b_word    cap_addr  [2];
    lc3b_word    cap_wdata [2];
    logic [1:0]  cap_be    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_mem(input lc3b_opcode op);
        return op inside {op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti};
    endfunction

    // Called just after a rising edge; runs one instruction through MEM and returns just after
    // the edge that retires it, checking every cycle against the access list derived up front.
    task automatic run_op(input lc3b_opcode op, input bit valid, input lc3b_word addr,
                          input lc3b_word sdata, input int n1, input int n2);
        bit          memop   = valid && tb_mem(op);
        bit          ind     = op inside {op_ldi, op_sti};
        bit          ld      = op inside {op_ldr, op_ldb, op_ldi};
        bit          byte_op = op inside {op_ldb, op_stb};
        lc3b_word    word_a  = {addr[15:1], 1'b0};
        lc3b_word    target;
        lc3b_word    exp_rd  = model_rdata;
        lc3b_word    w;
        lc3b_word    rv;
        lc3b_word    a_addr [2];
        lc3b_word    a_wdata[2];
        logic [1:0]  a_be   [2];
        bit          a_rd   [2];
        int          a_n    [2];
        int          nacc = 0;
        int          k = 0;
        int          kk;
        int          cnt = 0;
        bit          done_ph = 0;
        bit          req_exp;

        if (ind) begin
            a_addr[0] = word_a; a_rd[0] = 1; a_wdata[0] = sdata; a_be[0] = 2'b11; a_n[0] = n1;
            nacc = 1;
            w = mem_m[word_a[15:1]];
            target = {w[15:1], 1'b0};
        end else begin
            target = byte_op ? addr : word_a;
        end
        a_addr[nacc]  = target;
        a_rd[nacc]    = ld;
        a_wdata[nacc] = (op == op_stb) ? {sdata[7:0], sdata[7:0]} : sdata;
        a_be[nacc]    = (op == op_stb) ? (target[0] ? 2'b10 : 2'b01) : 2'b11;
        a_n[nacc]     = ind ? n2 : n1;
        nacc++;
        rv = mem_m[target[15:1]];
        if (op == op_ldb) exp_rd = {8'h00, (target[0] ? rv[15:8] : rv[7:0])};
        else if (ld)      exp_rd = rv;
        if (!memop) begin
            nacc = 0;
            exp_rd = model_rdata;
        end

        mem_valid = valid; mem_opcode = op; mem_address = addr; mem_store_data = sdata;
        last_stalls = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            dmem_resp  = 1'b0;
            dmem_rdata = lc3b_word'($urandom);
            if (cyc == 0 || done_ph) dmem_resp = ($urandom_range(0, 3) == 0);
            #1;
            req_exp = memop && (cyc != 0) && !done_ph;
            kk = (k < 2) ? k : 1;
            check("stall", mem_stall, memop && !done_ph);
            if (mem_stall) last_stalls++;
            check("read", dmem_read, req_exp && a_rd[kk]);
            check("write", dmem_write, req_exp && !a_rd[kk]);
            if (req_exp) begin
                check("address", dmem_address, a_addr[kk]);
                check("wdata", dmem_wdata, a_wdata[kk]);
                check("byte_enable", dmem_byte_enable, a_be[kk]);
                if (cnt == 0) begin
                    cap_addr[kk] = dmem_address; cap_wdata[kk] = dmem_wdata; cap_be[kk] = dmem_byte_enable;
                end
            end
            check("mem_rdata", mem_rdata, done_ph ? exp_rd : model_rdata);
            if (!memop || done_ph) begin
                model_rdata = exp_rd;
                if (memop && (op == op_str || op == op_sti)) mem_m[target[15:1]] = sdata;
                if (memop && op == op_stb) begin
                    w = mem_m[target[15:1]];
                    if (target[0]) w[15:8] = sdata[7:0]; else w[7:0] = sdata[7:0];
                    mem_m[target[15:1]] = w;
                end
                @(posedge clk); #1;
                return;
            end
            if (req_exp) begin
                cnt++;
                if (cnt >= a_n[kk]) begin
                    dmem_resp = 1'b1;
                    if (a_rd[kk]) dmem_rdata = mem_m[a_addr[kk][15:1]];
                    k++; cnt = 0;
                    if (k == nacc) done_ph = 1;
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL timeout: op %0d did not retire within 64 cycles at %0t", op, $time);
    endtask

    lc3b_opcode mops [6];
    lc3b_opcode rop;

    initial begin
        mops = '{op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti};
        reset_n = 1'b0; mem_valid = 1'b1; mem_opcode = op_ldr; mem_address = 16'h1111;
        mem_store_data = 16'h0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
        for (int i = 0; i < 32768; i++) mem_m[i] = 16'($urandom);
        model_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", mem_stall, 1);
        check("reset_read", dmem_read, 0);
        check("reset_write", dmem_write, 0);
        check("reset_address", dmem_address, 0);
        check("reset_wdata", dmem_wdata, 0);
        check("reset_be", dmem_byte_enable, 0);
        check("reset_rdata", mem_rdata, 0);
        reset_n = 1'b1;

        mem_m[16'h3004 >> 1] = 16'hBEEF;
        run_op(op_ldr, 1, 16'h3005, 16'h0, 2, 1);
        check("ldr_lit_rdata", mem_rdata, 16'hBEEF);
        check("ldr_lit_stall", last_stalls, 3);
        check("ldr_lit_addr", cap_addr[0], 16'h3004);
        check("ldr_lit_be", cap_be[0], 2'b11);

        mem_m[16'h2000 >> 1] = 16'hA55A;
        run_op(op_ldb, 1, 16'h2001, 16'h0, 1, 1);
        check("ldb_hi_lit", mem_rdata, 16'h00A5);
        run_op(op_ldb, 1, 16'h2000, 16'h0, 3, 1);
        check("ldb_lo_lit", mem_rdata, 16'h005A);

        run_op(op_stb, 1, 16'h2001, 16'h1234, 1, 1);
        check("stb_lit_wdata", cap_wdata[0], 16'h3434);
        check("stb_lit_be", cap_be[0], 2'b10);
        check("stb_lit_addr", cap_addr[0], 16'h2001);
        check("stb_keeps_rdata", mem_rdata, 16'h005A);

        mem_m[16'h4000 >> 1] = 16'h5002;
        mem_m[16'h5002 >> 1] = 16'h0077;
        run_op(op_ldi, 1, 16'h4000, 16'h0, 1, 3);
        check("ldi_lit_rdata", mem_rdata, 16'h0077);
        check("ldi_lit_stall", last_stalls, 5);
        check("ldi_lit_ptr_addr", cap_addr[1], 16'h5002);

        mem_m[16'h4000 >> 1] = 16'h6006;
        run_op(op_sti, 1, 16'h4001, 16'hCAFE, 2, 1);
        check("sti_lit_ptr_rd", cap_addr[0], 16'h4000);
        check("sti_lit_target", cap_addr[1], 16'h6006);
        check("sti_lit_wdata", cap_wdata[1], 16'hCAFE);
        run_op(op_add, 1, 16'h1234, 16'h0, 1, 1);
        check("add_after_sti_stall", last_stalls, 0);

        mem_valid = 1'b1; mem_opcode = op_ldr; mem_address = 16'h0246; dmem_resp = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_req", dmem_read, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_read", dmem_read, 0);
        check("rst_mid_addr", dmem_address, 0);
        check("rst_mid_stall", mem_stall, 1);
        check("rst_mid_rdata", mem_rdata, 0);
        model_rdata = 16'h0000;
        @(posedge clk); #1;
        reset_n = 1'b1; mem_valid = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
        #1;
        check("late_resp_stall", mem_stall, 0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        #1;
        check("late_resp_read", dmem_read, 0);
        check("late_resp_rdata", mem_rdata, 0);
        @(posedge clk); #1;
        mem_m[16'h0246 >> 1] = 16'h9C3E;
        run_op(op_ldr, 1, 16'h0246, 16'h0, 2, 1);
        check("post_reset_ldr", mem_rdata, 16'h9C3E);

        for (int t = 0; t < 300; t++) begin
            rop = lc3b_opcode'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) rop = mops[$urandom_range(0, 5)];
            run_op(rop, ($urandom_range(0, 9) != 0), lc3b_word'($urandom), lc3b_word'($urandom),
                   $urandom_range(1, 4), $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
